// File: rtl/debug_stream_pkg.sv
// Shared types and constants for the debug frame streamer: FSM state encoding,
// default frame header and byte-per-word helpers.
package debug_stream_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PC_SEND,
      WAIT,
      CAPTURE,
      REG_SEND,
      FINISH
   } state_t;

   localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
   localparam int         DEFAULT_WIDTH  = 32;

   function automatic int calc_bpw(input int width);
      return width / 8;
   endfunction

   // A one-byte word still needs a 1-bit index register.
   function automatic int calc_idx_w(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Shifts a word out MSB byte first over a valid/ready byte port; a load may
// also request a single-byte word taken from the top byte.
module word_byte_serializer
   import debug_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             load_single,
   input  logic [WIDTH-1:0] word,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   output logic             last_byte
);
   localparam int              BPW      = calc_bpw(WIDTH);
   localparam int              IDXW     = calc_idx_w(BPW);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BPW - 1);

   logic [WIDTH-1:0] r_shift;
   logic [7:0]       r_data;
   logic             r_valid;
   logic             r_single;
   logic [IDXW-1:0]  r_idx;
   logic             w_fire;

   assign w_fire    = r_valid && tx_ready;
   assign last_byte = r_valid && (r_single || (r_idx == LAST_IDX));
   assign tx_data   = r_data;
   assign tx_valid  = r_valid;

   // A load wins over a handshake so the next word follows the last byte gap-free.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift  <= '0;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_single <= 1'b0;
         r_idx    <= '0;
      end else if (load) begin
         r_data   <= word[WIDTH-1 -: 8];
         r_shift  <= word << 8;
         r_valid  <= 1'b1;
         r_single <= load_single;
         r_idx    <= '0;
      end else if (w_fire) begin
         if (last_byte) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
         end else begin
            r_data  <= r_shift[WIDTH-1 -: 8];
            r_shift <= r_shift << 8;
            r_idx   <= r_idx + IDXW'(1);
         end
      end
   end

endmodule

// File: rtl/debug_frame_streamer.sv
// Snapshots the PC, walks every debug register and streams
// header, PC and register bytes as one frame over a valid/ready byte port.
module debug_frame_streamer
   import debug_stream_pkg::*;
#(
   parameter int         WIDTH    = DEFAULT_WIDTH,
   parameter int         NUM_REGS = 16,
   parameter logic [7:0] HEADER   = HEADER_DEFAULT,
   parameter int         SETTLE   = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] fetchPC,
   input  logic [WIDTH-1:0] debug_reg_out,
   output logic [3:0]       debug_reg_select,
   output logic [7:0]       tx_data,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic             busy,
   output logic             done
);
   localparam logic [3:0] LAST_REG    = 4'(NUM_REGS - 1);
   localparam logic [3:0] SETTLE_INIT = 4'(SETTLE);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_pc_snap;
   logic [3:0]       r_select;
   logic [3:0]       r_settle;
   logic             w_ser_load;
   logic             w_ser_single;
   logic [WIDTH-1:0] w_ser_word;
   logic             w_last_byte;
   logic             w_fire_last;

   assign w_fire_last      = w_last_byte && tx_ready;
   assign debug_reg_select = r_select;

   // The serializer's shift register doubles as the captured register snapshot.
   word_byte_serializer #(.WIDTH(WIDTH)) u_ser (
      .clk        (clk),
      .reset      (reset),
      .load       (w_ser_load),
      .load_single(w_ser_single),
      .word       (w_ser_word),
      .tx_ready   (tx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .last_byte  (w_last_byte)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:     if (start)       w_state_next = HDR;
         HDR:      if (w_fire_last) w_state_next = PC_SEND;
         PC_SEND:  if (w_fire_last) w_state_next = WAIT;
         WAIT:     if (r_settle <= 4'd1) w_state_next = CAPTURE;
         CAPTURE:  w_state_next = REG_SEND;
         REG_SEND: if (w_fire_last) w_state_next = (r_select == LAST_REG) ? FINISH : WAIT;
         FINISH:   w_state_next = IDLE;
         default:  w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_ser_load   = 1'b0;
      w_ser_single = 1'b0;
      w_ser_word   = r_pc_snap;
      busy         = (r_state != IDLE);
      done         = (r_state == FINISH);
      case (r_state)
         IDLE: begin
            if (start) begin
               w_ser_load              = 1'b1;
               w_ser_single            = 1'b1;
               w_ser_word              = '0;
               w_ser_word[WIDTH-1 -: 8] = HEADER;
            end
         end
         HDR:     w_ser_load = w_fire_last;
         CAPTURE: begin
            w_ser_load = 1'b1;
            w_ser_word = debug_reg_out;
         end
         default: ;
      endcase
   end

   // Select only moves on a completed word, so it holds through any stall.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pc_snap <= '0;
         r_select  <= '0;
         r_settle  <= '0;
      end else begin
         case (r_state)
            IDLE: if (start) r_pc_snap <= fetchPC;
            PC_SEND: begin
               if (w_fire_last) begin
                  r_select <= '0;
                  r_settle <= SETTLE_INIT;
               end
            end
            WAIT: if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
            REG_SEND: begin
               if (w_fire_last && (r_select != LAST_REG)) begin
                  r_select <= r_select + 4'd1;
                  r_settle <= SETTLE_INIT;
               end
            end
            FINISH:  r_select <= '0;
            default: ;
         endcase
      end
   end

endmodule
